// File: rtl/jtag_tap_slv.sv
// JTAG TAP slave running entirely in the clk domain.
// TCK, TMS, TDI and TRST are oversampled through 2-flop synchronisers, and the
// TAP reacts only to the tck_rise / tck_fall strobes that come out of them.
// DR chains: IDCODE (32 bit), USER (32 bit) and BYPASS (1 bit).
module jtag_tap_slv #(
  parameter int               IRLEN      = 4,
  parameter logic [31:0]      IDCODE_VAL = 32'h1000_0CFD,
  parameter logic [IRLEN-1:0] USER_IR    = 4'h8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jtag_trst,
  input  logic             jtag_tck,
  input  logic             jtag_tms,
  input  logic             jtag_tdi,
  output logic             jtag_tdo,
  input  logic [31:0]      user_rdata,
  output logic [31:0]      user_wdata,
  output logic             user_upd,
  output logic [IRLEN-1:0] ir_out,
  output logic [3:0]       tap_state
);

  typedef enum logic [3:0] {
    TLR   = 4'h0, RTI   = 4'h1,
    SELDR = 4'h2, CAPDR = 4'h3, SHDR  = 4'h4, EX1DR = 4'h5,
    PSDR  = 4'h6, EX2DR = 4'h7, UPDDR = 4'h8,
    SELIR = 4'h9, CAPIR = 4'hA, SHIR  = 4'hB, EX1IR = 4'hC,
    PSIR  = 4'hD, EX2IR = 4'hE, UPDIR = 4'hF
  } tap_state_e;

  localparam logic [IRLEN-1:0] IR_IDCODE = {{(IRLEN-1){1'b0}}, 1'b1};
  localparam logic [IRLEN-1:0] IR_CAP    = {{(IRLEN-2){1'b0}}, 2'b01};

  logic [2:0]       tck_s_q;
  logic [1:0]       tms_s_q, tdi_s_q, trst_s_q;
  logic             tck_rise, tck_fall, tms_s, tdi_s, trst_s;
  tap_state_e       state_q, state_d;
  logic [IRLEN-1:0] ir_q, ir_sr_q;
  logic [31:0]      dr_sr_q, wdata_q;
  logic             byp_q, tdo_q, upd_q;
  logic             sel_id, sel_user, sel_byp;

  assign tck_rise = tck_s_q[1] & ~tck_s_q[2];
  assign tck_fall = ~tck_s_q[1] & tck_s_q[2];
  assign tms_s    = tms_s_q[1];
  assign tdi_s    = tdi_s_q[1];
  assign trst_s   = trst_s_q[1];

  // Instruction decode: anything that is neither IDCODE nor USER falls back to BYPASS.
  assign sel_id   = (ir_q == IR_IDCODE);
  assign sel_user = (ir_q == USER_IR) && !sel_id;
  assign sel_byp  = !sel_id && !sel_user;

  // Synchronise the JTAG pins; the third TCK flop provides the edge strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      tck_s_q  <= '0;
      tms_s_q  <= '0;
      tdi_s_q  <= '0;
      trst_s_q <= '0;
    end else begin
      tck_s_q  <= {tck_s_q[1:0], jtag_tck};
      tms_s_q  <= {tms_s_q[0], jtag_tms};
      tdi_s_q  <= {tdi_s_q[0], jtag_tdi};
      trst_s_q <= {trst_s_q[0], jtag_trst};
    end
  end

  // TAP state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= TLR;
    else     state_q <= state_d;
  end

  // IEEE 1149.1 next-state logic, advancing only on tck_rise; TRST overrides.
  always_comb begin
    state_d = state_q;
    if (trst_s) begin
      state_d = TLR;
    end else if (tck_rise) begin
      case (state_q)
        TLR:   state_d = tms_s ? TLR   : RTI;
        RTI:   state_d = tms_s ? SELDR : RTI;
        SELDR: state_d = tms_s ? SELIR : CAPDR;
        CAPDR: state_d = tms_s ? EX1DR : SHDR;
        SHDR:  state_d = tms_s ? EX1DR : SHDR;
        EX1DR: state_d = tms_s ? UPDDR : PSDR;
        PSDR:  state_d = tms_s ? EX2DR : PSDR;
        EX2DR: state_d = tms_s ? UPDDR : SHDR;
        UPDDR: state_d = tms_s ? SELDR : RTI;
        SELIR: state_d = tms_s ? TLR   : CAPIR;
        CAPIR: state_d = tms_s ? EX1IR : SHIR;
        SHIR:  state_d = tms_s ? EX1IR : SHIR;
        EX1IR: state_d = tms_s ? UPDIR : PSIR;
        PSIR:  state_d = tms_s ? EX2IR : PSIR;
        EX2IR: state_d = tms_s ? UPDIR : SHIR;
        UPDIR: state_d = tms_s ? SELDR : RTI;
        default: state_d = TLR;
      endcase
    end
  end

  // Capture/shift/update of IR and DR chains on tck_rise, TDO launch on tck_fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q    <= IR_IDCODE;
      ir_sr_q <= '0;
      dr_sr_q <= '0;
      byp_q   <= 1'b0;
      tdo_q   <= 1'b0;
      wdata_q <= '0;
      upd_q   <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      if (trst_s) begin
        // Shift contents are left as-is; user_wdata is deliberately kept.
        ir_q  <= IR_IDCODE;
        tdo_q <= 1'b0;
      end else begin
        if (tck_rise) begin
          case (state_q)
            CAPIR: ir_sr_q <= IR_CAP;
            SHIR:  ir_sr_q <= {tdi_s, ir_sr_q[IRLEN-1:1]};
            UPDIR: ir_q    <= ir_sr_q;
            CAPDR: begin
              if (sel_id)        dr_sr_q <= IDCODE_VAL;
              else if (sel_user) dr_sr_q <= user_rdata;
              else               byp_q   <= 1'b0;
            end
            SHDR: begin
              if (sel_byp) byp_q   <= tdi_s;
              else         dr_sr_q <= {tdi_s, dr_sr_q[31:1]};
            end
            UPDDR: begin
              if (sel_user) begin
                wdata_q <= dr_sr_q;
                upd_q   <= 1'b1;
              end
            end
            default: ;
          endcase
          // Entering or staying in TLR always restores IDCODE (never coincides with UPDIR).
          if (state_d == TLR) ir_q <= IR_IDCODE;
        end
        if (tck_fall) begin
          if (state_q == SHIR)      tdo_q <= ir_sr_q[0];
          else if (state_q == SHDR) tdo_q <= sel_byp ? byp_q : dr_sr_q[0];
          else                      tdo_q <= 1'b0;
        end
      end
    end
  end

  assign jtag_tdo   = tdo_q;
  assign user_wdata = wdata_q;
  assign user_upd   = upd_q;
  assign ir_out     = ir_q;
  assign tap_state  = state_q;

endmodule

// File: tb/tb_jtag_tap_slv.sv
// Self-checking bench for jtag_tap_slv: drives slow TCK cycles and compares
// serial traffic against a queue-based shift-chain model.
module tb_jtag_tap_slv;

  localparam logic [31:0] IDV  = 32'h1000_0CFD;
  localparam logic [3:0]  USER = 4'h8;

  logic        clk = 1'b0;
  logic        rst, jtag_trst, jtag_tck, jtag_tms, jtag_tdi, jtag_tdo;
  logic [31:0] user_rdata, user_wdata;
  logic        user_upd;
  logic [3:0]  ir_out, tap_state;

  int n_checks = 0;
  int n_fail   = 0;
  int upd_cnt  = 0;

  jtag_tap_slv #(.IRLEN(4), .IDCODE_VAL(IDV), .USER_IR(USER)) dut (
    .clk(clk), .rst(rst), .jtag_trst(jtag_trst), .jtag_tck(jtag_tck),
    .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo),
    .user_rdata(user_rdata), .user_wdata(user_wdata), .user_upd(user_upd),
    .ir_out(ir_out), .tap_state(tap_state)
  );

  always #5 clk = ~clk;

  // Counts clk cycles with user_upd high; a clean pulse adds exactly one.
  always @(posedge clk) if (user_upd === 1'b1) upd_cnt <= upd_cnt + 1;

  // Shift chain model: capture value loaded LSB first, each shift pops the
  // front to TDO and pushes TDI at the back.
  task automatic model_scan(input logic [31:0] cap, input int len, input logic [31:0] din,
                            input int n, output logic [31:0] exp_out, output logic [31:0] exp_reg);
    bit q[$];
    q = {};
    for (int i = 0; i < len; i++) q.push_back(cap[i]);
    exp_out = '0;
    for (int i = 0; i < n; i++) begin
      exp_out[i] = q.pop_front();
      q.push_back(din[i]);
    end
    exp_reg = '0;
    for (int i = 0; i < len; i++) exp_reg[i] = q[i];
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One TCK period: 6 clk low, 6 clk high. TDO is sampled just before the rise.
  task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo);
    jtag_tms = tms;
    jtag_tdi = tdi;
    idle(6);
    tdo = jtag_tdo;
    jtag_tck = 1'b1;
    idle(6);
    jtag_tck = 1'b0;
  endtask

  task automatic goto_tlr();
    logic b;
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, b);
  endtask

  // From RTI: load an IR opcode, returning the bits seen on TDO; ends in RTI.
  task automatic load_ir(input logic [3:0] op, output logic [3:0] cap);
    logic b;
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < 4; i++) begin
      tck_cycle(i == 3, op[i], b);
      cap[i] = b;
    end
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
  endtask

  // From RTI: full DR scan of n bits, optionally visiting Pause-DR after bit pause_at.
  task automatic scan_dr(input logic [31:0] din, input int n, input int pause_at,
                         output logic [31:0] dout);
    logic b;
    dout = '0;
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < n; i++) begin
      tck_cycle((i == n - 1) || (i == pause_at - 1), din[i], b);
      dout[i] = b;
      if ((i == pause_at - 1) && (i != n - 1)) begin
        tck_cycle(1'b0, 1'b1, b);
        tck_cycle(1'b0, 1'b1, b);
        tck_cycle(1'b0, 1'b0, b);
        tck_cycle(1'b1, 1'b1, b);
        tck_cycle(1'b0, 1'b0, b);
      end
    end
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
  endtask

  task automatic test_reset();
    logic b;
    rst = 1'b1; jtag_trst = 1'b0; jtag_tck = 1'b0; jtag_tms = 1'b0; jtag_tdi = 1'b0;
    user_rdata = '0;
    idle(4);
    n_checks++; if (tap_state !== 4'h0) begin n_fail++; $display("FAIL rst_state: got %h expected 0", tap_state); end
    n_checks++; if (ir_out !== 4'h1) begin n_fail++; $display("FAIL rst_ir: got %h expected 1", ir_out); end
    n_checks++; if (jtag_tdo !== 1'b0) begin n_fail++; $display("FAIL rst_tdo: got %b expected 0", jtag_tdo); end
    n_checks++; if (user_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h expected 0", user_wdata); end
    n_checks++; if (user_upd !== 1'b0) begin n_fail++; $display("FAIL rst_upd: got %b expected 0", user_upd); end
    rst = 1'b0;
    idle(2);
    goto_tlr();
    idle(4);
    n_checks++; if (tap_state !== 4'h0) begin n_fail++; $display("FAIL tlr_state: got %h expected 0", tap_state); end
    n_checks++; if (ir_out !== 4'h1) begin n_fail++; $display("FAIL tlr_ir: got %h expected 1", ir_out); end
    n_checks++; if (jtag_tdo !== 1'b0) begin n_fail++; $display("FAIL tlr_tdo: got %b expected 0", jtag_tdo); end
    tck_cycle(1'b0, 1'b0, b);
    n_checks++; if (tap_state !== 4'h1) begin n_fail++; $display("FAIL rti_state: got %h expected 1", tap_state); end
  endtask

  task automatic test_idcode();
    logic [31:0] din, dout, e, r;
    din = $urandom;
    scan_dr(din, 32, 0, dout);
    model_scan(IDV, 32, din, 32, e, r);
    n_checks++; if (dout !== e) begin n_fail++; $display("FAIL idcode_tdo: got %h expected %h", dout, e); end
    n_checks++; if (dout[0] !== 1'b1) begin n_fail++; $display("FAIL idcode_bit0: got %b expected 1", dout[0]); end
    n_checks++; if (tap_state !== 4'h1) begin n_fail++; $display("FAIL idcode_end_state: got %h expected 1", tap_state); end
  endtask

  task automatic test_bypass(input logic [3:0] op, input logic [31:0] din, input int n);
    logic [3:0]  cap;
    logic [31:0] dout, e, r, ie, ir;
    int c0;
    logic [31:0] w0;
    load_ir(op, cap);
    model_scan(32'h1, 4, {28'h0, op}, 4, ie, ir);
    n_checks++; if (cap !== ie[3:0]) begin n_fail++; $display("FAIL ir_capture: got %b expected %b", cap, ie[3:0]); end
    n_checks++; if (ir_out !== ir[3:0]) begin n_fail++; $display("FAIL ir_load: got %h expected %h", ir_out, ir[3:0]); end
    c0 = upd_cnt; w0 = user_wdata;
    scan_dr(din, n, 0, dout);
    model_scan(32'h0, 1, din, n, e, r);
    n_checks++; if (dout !== e) begin n_fail++; $display("FAIL bypass_tdo op=%h: got %h expected %h", op, dout, e); end
    n_checks++; if (upd_cnt !== c0) begin n_fail++; $display("FAIL bypass_upd: got %0d pulses expected 0", upd_cnt - c0); end
    n_checks++; if (user_wdata !== w0) begin n_fail++; $display("FAIL bypass_wdata: got %h expected %h", user_wdata, w0); end
  endtask

  task automatic test_user(input logic [31:0] rdata, input logic [31:0] din, input int pause_at);
    logic [3:0]  cap;
    logic [31:0] dout, e, r;
    int c0;
    user_rdata = rdata;
    load_ir(USER, cap);
    n_checks++; if (ir_out !== USER) begin n_fail++; $display("FAIL user_ir: got %h expected %h", ir_out, USER); end
    c0 = upd_cnt;
    scan_dr(din, 32, pause_at, dout);
    model_scan(rdata, 32, din, 32, e, r);
    n_checks++; if (dout !== e) begin n_fail++; $display("FAIL user_tdo: got %h expected %h", dout, e); end
    n_checks++; if (user_wdata !== r) begin n_fail++; $display("FAIL user_wdata: got %h expected %h", user_wdata, r); end
    n_checks++; if (upd_cnt !== c0 + 1) begin n_fail++; $display("FAIL user_upd: got %0d clk high expected 1", upd_cnt - c0); end
  endtask

  task automatic test_trst();
    logic [3:0]  cap;
    logic [31:0] w0, dout, e, r;
    logic        b;
    int c0;
    user_rdata = $urandom;
    load_ir(USER, cap);
    w0 = user_wdata; c0 = upd_cnt;
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < 10; i++) tck_cycle(1'b0, 1'($urandom), b);
    jtag_trst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (tap_state !== 4'h0) begin n_fail++; $display("FAIL trst_state: got %h expected 0", tap_state); end
    n_checks++; if (ir_out !== 4'h1) begin n_fail++; $display("FAIL trst_ir: got %h expected 1", ir_out); end
    idle(3);
    jtag_trst = 1'b0;
    idle(4);
    n_checks++; if (jtag_tdo !== 1'b0) begin n_fail++; $display("FAIL trst_tdo: got %b expected 0", jtag_tdo); end
    n_checks++; if (user_wdata !== w0) begin n_fail++; $display("FAIL trst_wdata: got %h expected %h", user_wdata, w0); end
    n_checks++; if (upd_cnt !== c0) begin n_fail++; $display("FAIL trst_upd: got %0d pulses expected 0", upd_cnt - c0); end
    tck_cycle(1'b0, 1'b0, b);
    scan_dr(32'hFFFF_0000, 32, 0, dout);
    model_scan(IDV, 32, 32'hFFFF_0000, 32, e, r);
    n_checks++; if (dout !== e) begin n_fail++; $display("FAIL trst_idcode: got %h expected %h", dout, e); end
  endtask

  task automatic test_rst_priority();
    logic b;
    n_checks++; if (tap_state !== 4'h1) begin n_fail++; $display("FAIL pre_rst_state: got %h expected 1", tap_state); end
    rst = 1'b1;
    tck_cycle(1'b0, 1'b1, b);
    tck_cycle(1'b0, 1'b1, b);
    n_checks++; if (tap_state !== 4'h0) begin n_fail++; $display("FAIL rstp_state: got %h expected 0", tap_state); end
    n_checks++; if (ir_out !== 4'h1) begin n_fail++; $display("FAIL rstp_ir: got %h expected 1", ir_out); end
    n_checks++; if (user_wdata !== 32'h0) begin n_fail++; $display("FAIL rstp_wdata: got %h expected 0", user_wdata); end
    rst = 1'b0;
    idle(4);
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_bypass(4'hF, 32'h0000_000D, 4);
    test_user(32'h1234_5678, 32'hA5A5_5A5A, 0);
    for (int k = 0; k < 3; k++)
      test_user($urandom, $urandom, int'($urandom_range(1, 31)));
    test_bypass(4'h3, $urandom, 8);
    test_bypass(4'($urandom_range(9, 14)), $urandom, 6);
    test_trst();
    test_rst_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_tap_slv.md
JTAG_TAP_SLV -- requirements
Module: jtag_tap_slv

Interface
REQ-001 Parameter IRLEN, default 4, instruction register width in bits.
REQ-002 Parameter IDCODE_VAL, default 32'h1000_0CFD, value captured by IDCODE; bit 0 SHALL be 1.
REQ-003 Parameter USER_IR, default 4'h8, opcode selecting the 32-bit USER data register.
REQ-004 clk  input  1  system clock; all logic SHALL run on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 jtag_trst  input  1  TAP reset from the JTAG master, active-high.
REQ-007 jtag_tck  input  1  JTAG clock, asynchronous to clk, oversampled.
REQ-008 jtag_tms  input  1  TAP mode select.
REQ-009 jtag_tdi  input  1  serial data in, LSB first.
REQ-010 jtag_tdo  output  1  serial data out, LSB first.
REQ-011 user_rdata  input  32  value captured into the USER register in Capture-DR.
REQ-012 user_wdata  output  32  USER register contents latched at Update-DR.
REQ-013 user_upd  output  1  one-clk pulse when user_wdata is updated.
REQ-014 ir_out  output  IRLEN  current instruction register.
REQ-015 tap_state  output  4  current TAP state encoding, for debug.

Function
REQ-016 jtag_tck, jtag_tms, jtag_tdi and jtag_trst SHALL each pass through a 2-flop synchroniser; a third flop on tck SHALL give tck_rise and tck_fall strobes.
REQ-017 The block SHALL require jtag_tck high and low phases of at least 4 clk periods each; behaviour at faster TCK is undefined.
REQ-018 On tck_rise the TAP FSM SHALL advance per IEEE 1149.1 on synchronised TMS, 3 clk edges after the raw TCK rise.
REQ-019 The FSM SHALL have 16 states: TLR, RTI, SelDR, CapDR, Shift-DR, Exit1DR, PauseDR, Exit2DR, UpdDR, and the same six-plus-select set for IR; encoding 4'h0 = TLR, 4'h1 = RTI, others are free.
REQ-020 Five consecutive tck_rise with TMS=1 SHALL reach TLR from any state.
REQ-021 In TLR, ir_out SHALL be IDCODE (4'h1).
REQ-022 On the tck_rise that leaves CapIR, the IR shift register SHALL load {zeros, 2'b01}.
REQ-023 On each tck_rise in Shift-IR or Shift-DR, the selected register SHALL shift right, with TDI entering at the MSB.
REQ-024 On the tck_rise that leaves UpdIR, ir_out SHALL load the IR shift register.
REQ-025 DR selection: IDCODE 4'h1 selects 32-bit IDCODE_VAL; USER_IR selects the 32-bit USER register; all-ones and any other opcode select 1-bit BYPASS.
REQ-026 CapDR loads: IDCODE_VAL, user_rdata, or 0 for BYPASS.
REQ-027 On the tck_rise that leaves UpdDR with USER_IR selected, user_wdata SHALL load the shift register and user_upd SHALL pulse high for exactly one clk.
REQ-028 Other instructions SHALL NOT pulse user_upd.
REQ-029 On tck_fall, jtag_tdo SHALL take the LSB of the active shift register when in Shift-IR or Shift-DR, and 0 otherwise.
REQ-030 Pause states SHALL hold shift-register contents unchanged.
REQ-031 Synchronised jtag_trst=1 SHALL force TLR, ir_out = IDCODE and jtag_tdo = 0 on the next clk, overriding any in-progress shift; user_wdata SHALL be retained.

Reset
REQ-032 While rst=1: tap_state = TLR, ir_out = 4'h1, jtag_tdo = 0, user_wdata = 0, user_upd = 0, shift registers = 0, synchroniser flops = 0.
REQ-033 rst SHALL take priority over every TCK event in the same cycle.

Verification
REQ-034 rst pulse, then 5 TCKs with TMS=1 -> tap_state = 4'h0, ir_out = 4'h1, jtag_tdo = 0.
REQ-035 From TLR, TMS sequence 0,1,0,0, then 32 shifts -> TDO bits equal IDCODE_VAL LSB-first (32'h1000_0CFD); bit 0 = 1.
REQ-036 Load IR 4'hF, then shift DR with TDI pattern 1,0,1,1 -> TDO = 0,1,0,1 (one-bit delay).
REQ-037 Load IR 4'h8 with user_rdata = 32'h1234_5678, shift in 32'hA5A5_5A5A -> TDO returns 32'h1234_5678; after UpdDR, user_wdata = 32'hA5A5_5A5A with a single-clk user_upd pulse.
REQ-038 jtag_trst pulsed after 10 of 32 Shift-DR bits -> tap_state = TLR and ir_out = 4'h1 within 3 clk; no user_upd pulse; user_wdata unchanged.
REQ-039 IR loaded with 4'h3 (undefined opcode) -> DR path behaves as BYPASS, as in REQ-036.
